// File: rtl/multi_timer.sv
// Multi-channel countdown timer for the peripheral bus. Each channel has a
// prescaler, one-shot or auto-reload mode and a sticky write-1-to-clear pending flag.
//
//   state  | meaning
//   S_IDLE | channel stopped; loads COUNT from PRESET once EN is seen
//   S_CNT  | channel running; prescaled ticks decrement COUNT
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int PSC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              TimerWe,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              IRQ
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CNT  = 1'b1
  } state_t;

  logic [CH_W-1:0]        ch_sel;
  logic                   ch_valid;
  logic [1:0]             reg_idx;
  logic [NUM_CH*32-1:0]   rd_flat;
  logic                   unused_bits;

  assign ch_sel      = ADDR[4 +: CH_W];
  assign reg_idx     = ADDR[3:2];
  assign ch_valid    = ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));
  assign unused_bits = ^{ADDR, Din};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic             wr_sel, tick, pend_set, pend_clr;
    logic [31:0]      rd_word;

    assign wr_sel = TimerWe && ch_valid && (ch_sel == CH_W'(c));
    assign tick   = (psc_cnt_q == psc_q);

    always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      mode_d    = mode_q;
      im_d      = im_q;
      psc_d     = psc_q;
      psc_cnt_d = psc_cnt_q;
      preset_d  = preset_q;
      count_d   = count_q;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;

      case (state_q)
        S_IDLE: begin
          if (en_q) begin
            count_d   = preset_q;
            psc_cnt_d = '0;
            state_d   = S_CNT;
          end
        end
        S_CNT: begin
          if (!en_q) begin
            state_d = S_IDLE;
          end else begin
            psc_cnt_d = tick ? '0 : psc_cnt_q + PSC_W'(1);
            if (tick) begin
              if (count_q > CNT_W'(1)) begin
                count_d = count_q - CNT_W'(1);
              end else begin
                // COUNT of 0 or 1 both expire, so PRESET=0 acts as PRESET=1
                pend_set = 1'b1;
                if (mode_q == 2'b01) begin
                  count_d = preset_q;
                end else begin
                  count_d = '0;
                  en_d    = 1'b0;
                  state_d = S_IDLE;
                end
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Bus writes land after the FSM so they win on the same register
      if (wr_sel) begin
        case (reg_idx)
          2'd0: begin
            en_d   = Din[0];
            mode_d = Din[2:1];
            im_d   = Din[3];
            psc_d  = Din[8 +: PSC_W];
          end
          2'd1: preset_d = Din[CNT_W-1:0];
          2'd2: count_d  = Din[CNT_W-1:0];
          2'd3: pend_clr = Din[0];
          default: ;
        endcase
      end

      pend_d = pend_set | (pend_q & ~pend_clr);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= S_IDLE;
        en_q      <= 1'b0;
        mode_q    <= 2'b00;
        im_q      <= 1'b0;
        psc_q     <= '0;
        psc_cnt_q <= '0;
        preset_q  <= '0;
        count_q   <= '0;
        pend_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        en_q      <= en_d;
        mode_q    <= mode_d;
        im_q      <= im_d;
        psc_q     <= psc_d;
        psc_cnt_q <= psc_cnt_d;
        preset_q  <= preset_d;
        count_q   <= count_d;
        pend_q    <= pend_d;
      end
    end

    always_comb begin
      rd_word = '0;
      case (reg_idx)
        2'd0: begin
          rd_word[0]            = en_q;
          rd_word[2:1]          = mode_q;
          rd_word[3]            = im_q;
          rd_word[8 +: PSC_W]   = psc_q;
        end
        2'd1: rd_word = 32'(preset_q);
        2'd2: rd_word = 32'(count_q);
        2'd3: begin
          rd_word[0] = pend_q;
          rd_word[1] = (state_q == S_CNT);
        end
        default: rd_word = '0;
      endcase
    end

    assign rd_flat[c*32 +: 32] = rd_word;
    assign irq_ch[c]           = pend_q & im_q;
  end

  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid && (ch_sel == CH_W'(i))) begin
        Dout = rd_flat[i*32 +: 32];
      end
    end
  end

  assign IRQ = |irq_ch;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural channel model.
module tb_multi_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        TimerWe;
  logic [31:0] ADDR;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [1:0]  irq_ch;
  logic        IRQ;

  logic        t3_we;
  logic [31:0] t3_addr;
  logic [31:0] t3_din;
  logic [31:0] t3_dout;
  logic [2:0]  t3_irq_ch;
  logic        t3_irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  multi_timer #(.NUM_CH(2), .CNT_W(32), .PSC_W(8)) u_dut (
    .clk(clk), .reset(reset), .TimerWe(TimerWe), .ADDR(ADDR), .Din(Din),
    .Dout(Dout), .irq_ch(irq_ch), .IRQ(IRQ)
  );

  multi_timer #(.NUM_CH(3), .CNT_W(32), .PSC_W(8)) u_dut3 (
    .clk(clk), .reset(reset), .TimerWe(t3_we), .ADDR(t3_addr), .Din(t3_din),
    .Dout(t3_dout), .irq_ch(t3_irq_ch), .IRQ(t3_irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[11];

  // behavioural model: one record per channel, tick phase from load time
  logic        m_en[2];
  logic [1:0]  m_mode[2];
  logic        m_im[2];
  logic [7:0]  m_psc[2];
  logic [31:0] m_pre[2];
  logic [31:0] m_cnt[2];
  logic        m_pend[2];
  logic        m_run[2];
  int          m_load[2];
  int          m_n;
  logic [7:0]  psc_fix[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ADDR = a;
    #1;
    chk(name, Dout, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    TimerWe = 1'b1;
    ADDR    = a;
    Din     = d;
    @(posedge clk);
    #1;
    TimerWe = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0;
      m_pre[c] = 0; m_cnt[c] = 0; m_pend[c] = 0; m_run[c] = 0; m_load[c] = 0;
    end
  endtask

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    for (int c = 0; c < 2; c++) begin
      logic set;
      set = 1'b0;
      if (!m_run[c]) begin
        if (m_en[c]) begin
          m_cnt[c]  = m_pre[c];
          m_run[c]  = 1'b1;
          m_load[c] = m_n;
        end
      end else if (!m_en[c]) begin
        m_run[c] = 1'b0;
      end else if (((m_n - m_load[c]) % (int'(m_psc[c]) + 1)) == 0) begin
        if (m_cnt[c] > 1) begin
          m_cnt[c] = m_cnt[c] - 1;
        end else begin
          set = 1'b1;
          if (m_mode[c] == 2'b01) m_cnt[c] = m_pre[c];
          else begin
            m_cnt[c] = 0;
            m_en[c]  = 1'b0;
            m_run[c] = 1'b0;
          end
        end
      end
      if (we && (int'(a[4]) == c)) begin
        case (a[3:2])
          2'd0: begin
            m_en[c] = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3]; m_psc[c] = d[15:8];
          end
          2'd1: m_pre[c] = d;
          2'd2: m_cnt[c] = d;
          default: if (d[0]) m_pend[c] = 1'b0;
        endcase
      end
      if (set) m_pend[c] = 1'b1;
    end
    m_n++;
  endtask

  function automatic logic [31:0] model_read(input int c, input int r);
    case (r)
      0:       return {16'h0, m_psc[c], 4'h0, m_im[c], m_mode[c], m_en[c]};
      1:       return m_pre[c];
      2:       return m_cnt[c];
      default: return {30'h0, m_run[c], m_pend[c]};
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; TimerWe = 1'b0; ADDR = '0; Din = '0;
    t3_we = 1'b0; t3_addr = '0; t3_din = '0;
    m_n = 0;
    model_clear();

    //            we    addr    din            raddr   exp_dout  irq
    vecs[0]  = '{1'b1, 32'h04, 32'h3,         32'h04, 32'h3,    1'b0};
    vecs[1]  = '{1'b1, 32'h00, 32'hA5A0_00F9, 32'h00, 32'h9,    1'b0};
    vecs[2]  = '{1'b0, 32'h00, 32'h0,         32'h08, 32'h3,    1'b0};
    vecs[3]  = '{1'b0, 32'h00, 32'h0,         32'h0C, 32'h2,    1'b0};
    vecs[4]  = '{1'b0, 32'h00, 32'h0,         32'h08, 32'h1,    1'b0};
    vecs[5]  = '{1'b0, 32'h00, 32'h0,         32'h08, 32'h0,    1'b1};
    vecs[6]  = '{1'b0, 32'h00, 32'h0,         32'h00, 32'h8,    1'b1};
    vecs[7]  = '{1'b0, 32'h00, 32'h0,         32'h0C, 32'h1,    1'b1};
    vecs[8]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 32'h0C, 32'h0,    1'b0};
    vecs[9]  = '{1'b1, 32'h14, 32'h7,         32'h14, 32'h7,    1'b0};
    vecs[10] = '{1'b0, 32'h00, 32'h0,         32'h04, 32'h3,    1'b0};

    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        rd_chk("reset_reg", 32'((c << 4) | (r << 2)), 32'h0);
    chk("reset_irq", {30'h0, irq_ch, IRQ}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      TimerWe = vecs[i].we; ADDR = vecs[i].addr; Din = vecs[i].din;
      @(posedge clk);
      #1;
      TimerWe = 1'b0;
      rd_chk($sformatf("vec%0d_dout", i), vecs[i].raddr, vecs[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq});
    end

    // ch1 auto-reload, PRESET=2, PSC=3: 8-cycle period, W1C between expiries
    wr(32'h14, 32'h2);
    wr(32'h10, 32'h30B);
    for (int t = 0; t < 19; t++) begin
      if (t == 10) wr(32'h1C, 32'h1);
      else step();
      rd_chk($sformatf("ar_count_t%0d", t), 32'h18, ((t % 8) < 4) ? 32'h2 : 32'h1);
      chk($sformatf("ar_irq_t%0d", t), {31'h0, irq_ch[1]},
          {31'h0, ((t >= 8 && t < 10) || t >= 16)});
      if (t == 10) rd_chk("ar_status_after_w1c", 32'h1C, 32'h2);
    end
    wr(32'h10, 32'h0);
    wr(32'h1C, 32'h1);
    wr(32'h0C, 32'h1);

    // simultaneous expiry, ch0 IM=0; W1C on ch1 in the expiry cycle loses
    wr(32'h04, 32'h2);
    wr(32'h14, 32'h1);
    wr(32'h00, 32'h1);
    wr(32'h10, 32'h9);
    step();
    wr(32'h1C, 32'h1);
    chk("sim_irq_ch", {30'h0, irq_ch}, 32'h2);
    chk("sim_irq", {31'h0, IRQ}, 32'h1);
    rd_chk("sim_pend0", 32'h0C, 32'h1);
    rd_chk("sim_pend1", 32'h1C, 32'h1);
    wr(32'h1C, 32'h1);
    rd_chk("sim_clr1", 32'h1C, 32'h0);
    chk("sim_irq_clr", {31'h0, IRQ}, 32'h0);
    wr(32'h0C, 32'h1);

    // COUNT write mid-count on ch0 while ch1 keeps its own prescaled ticks
    wr(32'h04, 32'd20);
    wr(32'h14, 32'd5);
    wr(32'h10, 32'h103);
    wr(32'h00, 32'h1);
    step(); step(); step();
    wr(32'h08, 32'd10);
    for (int i = 0; i < 3; i++) begin
      rd_chk($sformatf("cw_ch0_%0d", i), 32'h08, 32'(10 - i));
      rd_chk($sformatf("cw_ch1_%0d", i), 32'h18, 32'(5 - (4 + i) / 2));
      step();
    end

    // EN cleared at the edge that makes COUNT 5; it then holds
    step();
    rd_chk("dis_count6", 32'h08, 32'd6);
    wr(32'h00, 32'h0);
    step();
    rd_chk("dis_hold", 32'h08, 32'd5);
    rd_chk("dis_run0", 32'h0C, 32'h0);
    step();
    rd_chk("dis_hold2", 32'h08, 32'd5);
    wr(32'h00, 32'h1);
    step();
    rd_chk("reen_reload", 32'h08, 32'd20);
    rd_chk("reen_run", 32'h0C, 32'h2);

    // reset mid-count with a pending interrupt
    wr(32'h10, 32'h10B);
    begin
      int k;
      k = 0;
      while (!IRQ && k < 40) begin
        step();
        k++;
      end
    end
    chk("pre_reset_irq", {31'h0, IRQ}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        rd_chk("midrst_reg", 32'((c << 4) | (r << 2)), 32'h0);
    chk("midrst_irq", {30'h0, irq_ch, IRQ}, 32'h0);

    // 3-channel instance: channel 3 is absent; channel 2 with PRESET=0
    @(negedge clk); t3_we = 1'b1; t3_addr = 32'h30; t3_din = 32'h9;
    @(posedge clk); #1;
    @(negedge clk); t3_addr = 32'h34; t3_din = 32'h5;
    @(posedge clk); #1; t3_we = 1'b0;
    t3_addr = 32'h30; #1; chk("oor_ctrl", t3_dout, 32'h0);
    t3_addr = 32'h34; #1; chk("oor_preset", t3_dout, 32'h0);
    t3_addr = 32'h00; #1; chk("oor_alias0", t3_dout, 32'h0);
    t3_addr = 32'h10; #1; chk("oor_alias1", t3_dout, 32'h0);
    chk("oor_irq", {31'h0, t3_irq}, 32'h0);
    @(negedge clk); t3_we = 1'b1; t3_addr = 32'h20; t3_din = 32'h9;
    @(posedge clk); #1; t3_we = 1'b0;
    step();
    t3_addr = 32'h28; #1; chk("p0_count", t3_dout, 32'h0);
    t3_addr = 32'h2C; #1; chk("p0_run", t3_dout, 32'h2);
    step();
    t3_addr = 32'h2C; #1; chk("p0_expired", t3_dout, 32'h1);
    chk("p0_irq_ch", {29'h0, t3_irq_ch}, 32'h4);
    chk("p0_irq", {31'h0, t3_irq}, 32'h1);

    // random traffic against the model
    model_clear();
    for (int c = 0; c < 2; c++) psc_fix[c] = 8'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        we;
      logic [31:0] a, d;
      int          op, ch;
      @(negedge clk);
      TimerWe = 1'b0;
      reset   = 1'b0;
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 4; r++)
          rd_chk($sformatf("rnd_c%0d_r%0d", c, r), 32'((c << 4) | (r << 2)), model_read(c, r));
      chk("rnd_irq_ch", {30'h0, irq_ch}, {30'h0, m_pend[1] & m_im[1], m_pend[0] & m_im[0]});
      chk("rnd_irq", {31'h0, IRQ},
          {31'h0, (m_pend[0] & m_im[0]) | (m_pend[1] & m_im[1])});
      we = 1'b0; a = '0; d = '0;
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, 1);
      case (op)
        4, 5: begin
          logic [3:0] lo;
          lo = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 3) != 0) lo[0] = 1'b1;
          we = 1'b1; a = 32'(ch << 4);
          d = ($urandom & 32'hFFFF_00F0) | {16'h0, psc_fix[ch], 4'h0, lo};
        end
        6: begin we = 1'b1; a = 32'((ch << 4) | 4);  d = 32'($urandom_range(0, 6)); end
        7: begin we = 1'b1; a = 32'((ch << 4) | 8);  d = 32'($urandom_range(0, 8)); end
        8: begin we = 1'b1; a = 32'((ch << 4) | 12); d = $urandom; end
        default: ;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_clear();
        m_n++;
      end else begin
        TimerWe = we; ADDR = a; Din = d;
        model_step(we, a, d);
      end
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel countdown timer for the MIPS microsystem's memory-mapped peripheral bus. It generalises the single-channel timer to NUM_CH independent channels. Each channel has configurable counter width, a clock prescaler, one-shot or auto-reload mode, and a sticky, write-1-to-clear pending flag. It sits on the bridge next to the UART and drives one combined interrupt line into CP0, plus a per-channel interrupt vector.

## Interface
- NUM_CH, 2: channel count, 1..8; CH_W = max(1, clog2(NUM_CH)).
- CNT_W, 32: PRESET/COUNT width, 1..32; reads zero-extended, writes truncated.
- PSC_W, 8: prescaler field width, 1..8.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- TimerWe  in  1  write strobe for the addressed register.
- ADDR  in  32  byte address: [3:2] register index, [4+CH_W-1:4] channel.
- Din  in  32  write data.
- Dout  out  32  combinational read data of the addressed register.
- irq_ch  out  NUM_CH  per channel: PEND & IM.
- IRQ  out  1  OR of irq_ch.

## Operation
- Register index 0, CTRL:
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x behaves as one-shot but reads back as written.
  - [3] IM.
  - [8+PSC_W-1:8] PSC.
  - All other bits are not stored and read 0.
- Register index 1, PRESET.
- Register index 2, COUNT.
- Register index 3, STATUS:
  - [0] PEND, write 1 to clear.
  - [1] RUN, read-only, 1 while in CNT.
  - Other bits read 0.
- Channel index ≥ NUM_CH: reads return 0, writes are ignored.
- Per-channel FSM with states IDLE and CNT:
  - IDLE with EN=1: COUNT<=PRESET, psc_cnt<=0, go to CNT.
  - CNT with EN=0: go to IDLE; COUNT holds its value.
  - CNT tick: psc_cnt==PSC gives a tick and psc_cnt<=0; otherwise psc_cnt increments.
  - On a tick with COUNT>1: COUNT decrements.
  - On a tick with COUNT≤1 (expiry): PEND<=1.
    - One-shot: COUNT<=0, EN<=0, go to IDLE.
    - Auto-reload: COUNT<=PRESET, stay in CNT.
  - PRESET=0 behaves as PRESET=1.
- Bus write vs self-update priority, per channel only:
  - A write to a channel's CTRL or COUNT overrides that channel's FSM update of the same register in that cycle.
  - The FSM state and other registers still update normally.
  - Other channels are never stalled by writes.
- A COUNT write while in CNT takes effect; decrementing continues from the written value.
- A PRESET write affects only the next load or reload.
- If a PEND set and a W1C happen in the same cycle, the set wins.
- Reset: every register, psc_cnt and state clear to 0/IDLE. Dout, irq_ch and IRQ are then 0.

## Timing
- Register writes take effect at the clk edge where TimerWe=1.
- Dout is zero-latency combinational; it reflects register state after the last edge.
- Enable write at edge E0 loads COUNT at edge E1.
- Ticks occur at E1+k·(PSC+1), k≥1. Expiry is at E1+max(PRESET,1)·(PSC+1).
- PEND, and therefore irq_ch/IRQ (if IM=1), go high in the cycle after the expiry edge.
- Auto-reload period is max(PRESET,1)·(PSC+1) cycles, with no dead cycle between periods.
- Clearing EN mid-count freezes COUNT at the next edge.
  - Re-enabling reloads from PRESET; there is no resume.
- Reset asserted mid-count clears everything at that edge; nothing remains pending.

## Test plan
- Ch0 PRESET=3, CTRL=0x9 at E0 → COUNT reads 3,2,1,0 after E1..E4; IRQ=1 after E4; CTRL reads 0x8; RUN=0.
- Ch1 PRESET=2, PSC=3, MODE=01, IM=1 → PEND every 8 cycles; W1C STATUS=1 clears IRQ until the next expiry; COUNT reloads to 2 with no dead cycle.
- Ch0 and ch1 expire in the same cycle, ch0 IM=0 → irq_ch=2'b10, IRQ=1, both PEND=1; W1C on ch1 in the expiry cycle → PEND stays 1.
- Write COUNT=10 to ch0 mid-count → next reads 10,9,...; ch1 counting simultaneously loses no tick.
- Write CTRL EN=0 at COUNT=5 → COUNT holds 5, RUN=0; re-enable → COUNT=PRESET.
- Reset mid-count with PEND=1 → all reads 0, IRQ=0; a channel address ≥ NUM_CH reads 0 and ignores writes.
